// File: rtl/mm2s_stream_packer_if.sv
// rtl/mm2s_stream_packer_if.sv - AXI-Stream beat channel between packer and S2MM sink
interface mm2s_stream_packer_if #(
   parameter int D_W   = 32,
   parameter int LANES = 2
);
   logic [LANES*D_W-1:0]   tdata;
   logic [LANES*D_W/8-1:0] tkeep;
   logic                   tlast;
   logic                   tvalid;
   logic                   tready;

   modport master (output tdata, tkeep, tlast, tvalid, input tready);
   modport slave  (input tdata, tkeep, tlast, tvalid, output tready);
endinterface

// File: rtl/mm2s_stream_packer.sv
// rtl/mm2s_stream_packer.sv - banks a column-written result matrix and streams it as packed AXI-Stream beats
module mm2s_stream_packer #(
   parameter int D_W    = 32,
   parameter int N1     = 4,
   parameter int LANES  = 2,
   parameter int ADDR_W = 10,
   parameter int DEPTH  = 1024,
   parameter int CNT_W  = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [CNT_W-1:0]     num_words,
   input  logic [N1-1:0]        wr_valid,
   input  logic [N1*D_W-1:0]    wr_data,
   mm2s_stream_packer_if.master m_axis,
   output logic                 busy,
   output logic                 done_pulse,
   output logic                 wr_drop
);
   localparam int KEEP_W = LANES*D_W/8;
   localparam int BYTES  = D_W/8;
   localparam int BW     = (N1 > 1) ? $clog2(N1) : 1;
   localparam int LW     = $clog2(LANES+1);
   localparam int CW1    = CNT_W+1;
   localparam int AW1    = ADDR_W+1;

   typedef enum logic [1:0] {IDLE, FILL, READ, DRAIN} state_t;
   state_t state;

   logic [AW1-1:0]    rows_q;
   logic [CNT_W-1:0]  beats_q;
   logic [LW-1:0]     tail_lanes_q;
   logic [AW1-1:0]    wptr [N1];

   logic [N1-1:0]     we;
   logic              drop_now;
   logic              all_full;
   logic [CW1-1:0]    nw_ext;
   logic [CW1-1:0]    beats_calc;

   logic [CNT_W-1:0]  issue_cnt;
   logic [ADDR_W-1:0] issue_row;
   logic [BW-1:0]     issue_base;
   logic              issue;
   logic              issue_last;
   logic [KEEP_W-1:0] issue_keep;

   logic              rd_valid;
   logic [BW-1:0]     rd_base;
   logic              rd_last;
   logic [KEEP_W-1:0] rd_keep;
   logic [N1*D_W-1:0] rd_bus;
   logic [LANES*D_W-1:0] push_data;

   logic [LANES*D_W-1:0] f_data [3];
   logic [KEEP_W-1:0]    f_keep [3];
   logic                 f_last [3];
   logic [1:0]           f_wp;
   logic [1:0]           f_rp;
   logic [1:0]           fifo_cnt;
   logic                 pop;

   // Completion is judged on the pointers as they will be after this cycle's writes.
   always_comb begin
      we       = '0;
      drop_now = 1'b0;
      all_full = 1'b1;
      for (int b = 0; b < N1; b++) begin
         if (wr_valid[b]) begin
            if (state == FILL && wptr[b] != rows_q) we[b] = 1'b1;
            else                                    drop_now = 1'b1;
         end
         if ((wptr[b] + AW1'(we[b])) != rows_q) all_full = 1'b0;
      end
   end

   always_comb begin
      nw_ext     = {1'b0, num_words};
      beats_calc = (nw_ext + CW1'(LANES-1)) / CW1'(LANES);
   end

   // Credit covers the FIFO plus the one beat that may be in the bank read stage.
   always_comb begin
      issue      = (state == READ) && (({1'b0, fifo_cnt} + {2'b0, rd_valid}) < 3'd3);
      issue_last = (issue_cnt == beats_q - CNT_W'(1));
      issue_keep = '0;
      for (int l = 0; l < LANES; l++) begin
         issue_keep[l*BYTES +: BYTES] = {BYTES{!issue_last || (LW'(l) < tail_lanes_q)}};
      end
   end

   for (genvar b = 0; b < N1; b++) begin : g_bank
      logic [D_W-1:0] mem [DEPTH];
      logic [D_W-1:0] rd_word;
      always_ff @(posedge clk) begin
         if (we[b]) mem[wptr[b][ADDR_W-1:0]] <= wr_data[b*D_W +: D_W];
         if (issue) rd_word <= mem[issue_row];
      end
      assign rd_bus[b*D_W +: D_W] = rd_word;
   end

   always_comb begin
      push_data = '0;
      for (int l = 0; l < LANES; l++) begin
         if (rd_keep[l*BYTES]) push_data[l*D_W +: D_W] = rd_bus[(int'(rd_base) + l)*D_W +: D_W];
      end
   end

   always_ff @(posedge clk) begin
      if (rd_valid) begin
         f_data[f_wp] <= push_data;
         f_keep[f_wp] <= rd_keep;
         f_last[f_wp] <= rd_last;
      end
   end

   assign pop           = m_axis.tvalid && m_axis.tready;
   assign m_axis.tvalid = (fifo_cnt != 2'd0);
   assign m_axis.tdata  = m_axis.tvalid ? f_data[f_rp] : '0;
   assign m_axis.tkeep  = m_axis.tvalid ? f_keep[f_rp] : '0;
   assign m_axis.tlast  = m_axis.tvalid && f_last[f_rp];

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         rows_q       <= '0;
         beats_q      <= '0;
         tail_lanes_q <= '0;
         issue_cnt    <= '0;
         issue_row    <= '0;
         issue_base   <= '0;
         rd_valid     <= 1'b0;
         rd_base      <= '0;
         rd_last      <= 1'b0;
         rd_keep      <= '0;
         f_wp         <= '0;
         f_rp         <= '0;
         fifo_cnt     <= '0;
         busy         <= 1'b0;
         done_pulse   <= 1'b0;
         wr_drop      <= 1'b0;
         for (int b = 0; b < N1; b++) wptr[b] <= '0;
      end else begin
         done_pulse <= 1'b0;
         wr_drop    <= wr_drop | drop_now;
         rd_valid   <= issue;
         if (issue) begin
            rd_base <= issue_base;
            rd_last <= issue_last;
            rd_keep <= issue_keep;
         end
         if (rd_valid) f_wp <= (f_wp == 2'd2) ? 2'd0 : f_wp + 2'd1;
         if (pop)      f_rp <= (f_rp == 2'd2) ? 2'd0 : f_rp + 2'd1;
         fifo_cnt <= fifo_cnt + {1'b0, rd_valid} - {1'b0, pop};
         for (int b = 0; b < N1; b++) begin
            if (we[b]) wptr[b] <= wptr[b] + AW1'(1);
         end

         case (state)
            IDLE: begin
               if (start) begin
                  rows_q       <= AW1'((nw_ext + CW1'(N1-1)) / CW1'(N1));
                  beats_q      <= beats_calc[CNT_W-1:0];
                  tail_lanes_q <= LW'(nw_ext - (beats_calc - CW1'(1)) * CW1'(LANES));
                  issue_cnt    <= '0;
                  issue_row    <= '0;
                  issue_base   <= '0;
                  busy         <= 1'b1;
                  state        <= FILL;
                  for (int b = 0; b < N1; b++) wptr[b] <= '0;
               end
            end
            FILL: begin
               if (all_full) state <= READ;
            end
            READ: begin
               if (issue) begin
                  issue_cnt <= issue_cnt + CNT_W'(1);
                  if (int'(issue_base) + LANES >= N1) begin
                     issue_base <= '0;
                     issue_row  <= issue_row + ADDR_W'(1);
                  end else begin
                     issue_base <= issue_base + BW'(LANES);
                  end
                  if (issue_last) state <= DRAIN;
               end
            end
            DRAIN: begin
               if (pop && m_axis.tlast) begin
                  state      <= IDLE;
                  busy       <= 1'b0;
                  done_pulse <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mm2s_stream_packer.sv
// tb/tb_mm2s_stream_packer.sv - scoreboard bench for mm2s_stream_packer
module tb_mm2s_stream_packer;
   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [15:0]  num_words;
   logic [3:0]   wr_valid;
   logic [127:0] wr_data;
   logic         busy;
   logic         done_pulse;
   logic         wr_drop;

   mm2s_stream_packer_if #(.D_W(32), .LANES(2)) axis ();

   mm2s_stream_packer #(
      .D_W(32), .N1(4), .LANES(2), .ADDR_W(10), .DEPTH(1024), .CNT_W(16)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .num_words(num_words),
      .wr_valid(wr_valid), .wr_data(wr_data), .m_axis(axis),
      .busy(busy), .done_pulse(done_pulse), .wr_drop(wr_drop)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [63:0] data;
      logic [7:0]  keep;
      logic        last;
   } beat_t;

   beat_t exp_q[$];
   beat_t held;
   int    checks = 0;
   int    errors = 0;
   int    done_cnt = 0;
   int    tready_mode = 1;
   bit    expect_done = 1'b0;
   bit    stall_prev = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] wval(input int vbase, input int n, input int w);
      return (w < n) ? 32'(vbase + w) : 32'hDEAD0000 + 32'(w);
   endfunction

   initial begin
      axis.tready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         case (tready_mode)
            0:       axis.tready = 1'b0;
            1:       axis.tready = 1'b1;
            default: axis.tready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   always @(negedge clk) begin
      if (rst) begin
         stall_prev  = 1'b0;
         expect_done = 1'b0;
      end else begin
         if (done_pulse) done_cnt++;
         if (expect_done) begin
            chk("done_pulse_busy", {done_pulse, busy}, 2'b10);
            expect_done = 1'b0;
         end
         if (stall_prev) begin
            chk("stall_hold", {axis.tvalid, axis.tdata, axis.tkeep, axis.tlast},
                {1'b1, held.data, held.keep, held.last});
         end
         if (axis.tvalid && axis.tready) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_beat", {axis.tdata[62:0], axis.tlast}, 64'h0);
               errors += (axis.tdata == 64'h0 && !axis.tlast) ? 1 : 0;
            end else begin
               beat_t e;
               e = exp_q.pop_front();
               chk("beat", {axis.tdata[55:0], axis.tkeep}, {e.data[55:0], e.keep});
               chk("beat_hi_last", {axis.tdata[63:56], axis.tlast}, {e.data[63:56], e.last});
               if (axis.tlast) expect_done = 1'b1;
            end
         end
         stall_prev = axis.tvalid && !axis.tready;
         held       = '{data: axis.tdata, keep: axis.tkeep, last: axis.tlast};
      end
   end

   task automatic start_matrix(input int n, input int vbase, input bit skew, input bit extra);
      int rows;
      int beats;
      int cmax;
      int lat;
      int r;
      rows  = (n + 3) / 4;
      beats = (n + 1) / 2;
      for (int k = 0; k < beats; k++) begin
         beat_t e;
         e = '0;
         e.last = (k == beats - 1);
         for (int l = 0; l < 2; l++) begin
            if (2*k + l < n) begin
               e.data[l*32 +: 32] = wval(vbase, n, 2*k + l);
               e.keep[l*4 +: 4]   = 4'hF;
            end
         end
         exp_q.push_back(e);
      end
      @(posedge clk); #1;
      start     = 1'b1;
      num_words = 16'(n);
      @(posedge clk); #1;
      start = 1'b0;
      cmax  = rows - 1 + (skew ? 3 : 0);
      for (int c = 0; c <= cmax; c++) begin
         wr_valid = '0;
         wr_data  = '0;
         for (int b = 0; b < 4; b++) begin
            r = c - (skew ? b : 0);
            if (r >= 0 && r < rows) begin
               wr_valid[b]          = 1'b1;
               wr_data[b*32 +: 32]  = wval(vbase, n, r*4 + b);
            end
         end
         if (extra && c == rows) begin
            wr_valid[0]   = 1'b1;
            wr_data[31:0] = 32'h0BAD0BAD;
         end
         @(posedge clk); #1;
      end
      wr_valid = '0;
      lat = 0;
      while (lat < 20) begin
         @(negedge clk);
         lat++;
         if (axis.tvalid) break;
      end
      chk("first_tvalid_latency", 64'(lat), 64'd3);
   endtask

   task automatic wait_done(input int prev);
      int c;
      c = 0;
      while ((exp_q.size() != 0 || done_cnt == prev) && c < 3000) begin
         @(posedge clk);
         c++;
      end
      chk("done_timeout", 64'(c < 3000), 64'd1);
      @(negedge clk);
      chk("busy_after_done", 64'(busy), 64'd0);
   endtask

   initial begin
      int p;
      rst = 1'b1; start = 1'b0; num_words = '0; wr_valid = '0; wr_data = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("reset_tvalid", 64'(axis.tvalid), 64'd0);
      chk("reset_tlast", 64'(axis.tlast), 64'd0);
      chk("reset_tkeep", 64'(axis.tkeep), 64'd0);
      chk("reset_tdata", axis.tdata, 64'd0);
      chk("reset_busy", 64'(busy), 64'd0);
      chk("reset_done", 64'(done_pulse), 64'd0);
      chk("reset_wr_drop", 64'(wr_drop), 64'd0);

      tready_mode = 1;
      p = done_cnt; start_matrix(8, 0, 1'b0, 1'b0);       wait_done(p);
      p = done_cnt; start_matrix(7, 'h100, 1'b0, 1'b0);   wait_done(p);
      tready_mode = 2;
      p = done_cnt; start_matrix(64, 'h1000, 1'b0, 1'b0); wait_done(p);
      tready_mode = 1;
      p = done_cnt; start_matrix(16, 'h2000, 1'b1, 1'b0); wait_done(p);
      chk("wr_drop_clean", 64'(wr_drop), 64'd0);

      @(posedge clk); #1 wr_valid = 4'b0010;
      @(posedge clk); #1 wr_valid = 4'b0000;
      @(negedge clk);
      chk("wr_drop_idle", 64'(wr_drop), 64'd1);
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("wr_drop_rst", 64'(wr_drop), 64'd0);

      p = done_cnt; start_matrix(8, 'h3000, 1'b1, 1'b1);  wait_done(p);
      chk("wr_drop_fill_held", 64'(wr_drop), 64'd1);

      tready_mode = 0;
      start_matrix(8, 'h4000, 1'b0, 1'b0);
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("rst_tvalid", 64'(axis.tvalid), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      exp_q.delete();
      @(posedge clk); #1 rst = 1'b0;
      tready_mode = 1;
      p = done_cnt; start_matrix(4, 'h5000, 1'b0, 1'b0);  wait_done(p);
      chk("wr_drop_after_rst", 64'(wr_drop), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/mm2s_stream_packer.md
# mm2s_stream_packer

Parametrised successor to the result-drain path: buffers a result matrix written column-banked by the systolic array into N1 internal BRAM banks, then streams it out over AXI-Stream packed LANES words per beat, with true valid/ready handshaking, a partial final beat and a done pulse. It sits between the array's D outputs and the DMA S2MM channel, in a single clock domain.

## Interface
- D_W, 32, result word width; multiple of 8
- N1, 4, bank count (array output columns)
- LANES, 2, words per AXI beat; N1 % LANES == 0
- ADDR_W, 10, bank address width
- DEPTH, 1024, words per bank (≤ 2^ADDR_W)
- CNT_W, 16, width of num_words
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  arm a new matrix; sampled in IDLE only
- num_words  in  CNT_W  total result words; sampled with start; 1 ≤ num_words ≤ N1*DEPTH
- wr_valid  in  N1  per-bank write strobe
- wr_data  in  N1*D_W  per-bank write data, bank b at [b*D_W +: D_W]
- m_axis_tdata  out  LANES*D_W  lane l at [l*D_W +: D_W]
- m_axis_tkeep  out  LANES*D_W/8  byte enables
- m_axis_tlast  out  1  final beat
- m_axis_tvalid  out  1  beat valid
- m_axis_tready  in  1  sink ready
- busy  out  1  high outside IDLE
- done_pulse  out  1  one cycle after final beat accepted
- wr_drop  out  1  sticky: write strobe outside FILL or beyond row count

## Operation
- rows = ceil(num_words/N1); beats = ceil(num_words/LANES); both latched on start.
- Word index w maps to bank w % N1, row w / N1. Beat k carries words k*LANES..k*LANES+LANES-1, all in row (k*LANES)/N1, banks (k*LANES)%N1 upward.
- States: IDLE, FILL, READ, DRAIN.
- IDLE: start -> FILL; per-bank write pointers cleared.
- FILL: wr_valid[b] writes wr_data bank b at wptr[b], wptr[b]++. Strobe on a bank with wptr[b]==rows is dropped and sets wr_drop. When every wptr[b]==rows (evaluated after this cycle's writes) -> READ next cycle.
- READ: issues one beat read per cycle when credit allows; after issuing beat beats-1 -> DRAIN.
- DRAIN: when final beat handshakes -> IDLE, done_pulse high one cycle.
- tkeep: all ones except final beat; lanes l ≥ num_words - (beats-1)*LANES have their bytes cleared, their tdata driven zero.
- tlast high only on beat beats-1.
- wr_valid in IDLE/READ/DRAIN: ignored, sets wr_drop. wr_drop clears only on rst.
- start outside IDLE ignored.

## Timing
- Reset values: tvalid 0, tlast 0, tkeep 0, tdata 0, busy 0, done_pulse 0, wr_drop 0; state IDLE; FIFO empty; all counters 0.
- Bank read latency 1 cycle; read data enters a 3-entry output FIFO; FIFO head drives the AXI outputs.
- Beat issued in cycle t is visible on tvalid at t+2 earliest.
- Issue allowed when occupancy + in-flight < 3 (same-cycle pop not credited). With tready held high: one beat per cycle sustained.
- AXI rules: tvalid never deasserts and tdata/tkeep/tlast never change while tvalid && !tready; beat transfers on tvalid && tready.
- FILL->READ: first tvalid 3 cycles after the cycle completing the last row write.
- done_pulse: the cycle after the tlast handshake; busy falls the same cycle.
- rst mid-operation: all state abandoned next edge; FIFO flushed; tvalid 0; bank contents undefined and not read.

## Test plan
- N1=4, LANES=2, num_words=8, rows 0..1 written with values 0..7, tready=1 -> 4 beats {1,0},{3,2},{5,4},{7,6}, tlast on beat 3, tkeep all 1, done_pulse next cycle.
- num_words=7 (rows=2, bank 3 row 1 still written) -> 4 beats, final beat lane0=6, lane1 tdata 0, tkeep 8'h0F, tlast set.
- tready toggling 1,0,0,1 pseudo-randomly during 64-word read -> every beat delivered once, in order, outputs stable while stalled, no gaps beyond stall cycles.
- Banks written with skew (bank b starts b cycles late, systolic pattern) -> READ entered only after bank 3's final write; data order correct.
- Extra wr_valid on bank 0 after wptr==rows, and a strobe in IDLE -> write dropped, wr_drop=1 and held until rst.
- rst asserted mid-READ with tvalid=1 -> next cycle tvalid=0, busy=0; new start with num_words=4 completes normally with fresh data.
